gamma_loader: RTL and testbench

- Controller that sequences writes into the video mixer's gamma-correction LUT (768 entries: 3 channels x 256).
- On reset, builds an identity table.
- Loads user gamma tables streamed byte-wise from the HPS over a valid/ready interface.
- Gates the mixer's gamma_en so that a table is only ever switched in or out at VBlank start; no mid-frame change.

---
 rtl/gamma_pkg.sv | 47 ++++
 rtl/gamma_loader_sync_rise.sv | 25 ++
 rtl/gamma_loader.sv | 151 +++++++++++++++
 tb/tb_gamma_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gamma_pkg.sv
// Shared types and address sequencing for the gamma LUT loader.
package gamma_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ARM,
        LOAD,
        COMMIT_WAIT
    } state_t;

    localparam int unsigned GAMMA_ENTRIES = 768;
    localparam int unsigned ADDR_W        = 10;
    localparam int unsigned DATA_W        = 8;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    localparam logic [7:0] LAST_IDX = 8'(GAMMA_ENTRIES / 3 - 1);

    // LUT address as seen on gamma_wr_addr: {chan, idx}
    typedef struct packed {
        logic [1:0] chan;
        logic [7:0] idx;
    } lut_addr_t;

    // Channel-interleaved walk: R,G,B of one index, then the next index
    function automatic lut_addr_t next_addr(input lut_addr_t a);
        lut_addr_t n;
        n = a;
        case (a.chan)
            CH_R:    n.chan = CH_G;
            CH_G:    n.chan = CH_B;
            default: begin
                n.chan = CH_R;
                n.idx  = a.idx + 8'd1;
            end
        endcase
        return n;
    endfunction

    function automatic logic is_last(input lut_addr_t a);
        return (a.chan == CH_B) && (a.idx == LAST_IDX);
    endfunction

endpackage

// File: rtl/gamma_loader_sync_rise.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/gamma_loader.sv
// Sequences identity and host-streamed tables into the mixer gamma LUT and
// switches gamma_en only at VBlank boundaries.
module gamma_loader
    import gamma_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1000000,
    parameter bit          VB_SYNC = 1'b1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              user_en,
    input  logic              init_req,
    input  logic              load_start,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    input  logic              vblank,
    output logic              gamma_en,
    output logic              gamma_wr,
    output logic [ADDR_W-1:0] gamma_wr_addr,
    output logic [DATA_W-1:0] gamma_value,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t            state, state_n;
    lut_addr_t         ptr, ptr_n;
    logic              table_valid, tv_n;
    logic [CNT_W-1:0]  idle_cnt, idle_cnt_n;
    logic              err_n, wr_n, done_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] val_n;
    logic              vb_rise, vb_go_c, xfer_c;

    sync_rise u_vb_sync (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .d     (vblank),
        .rise  (vb_rise)
    );

    assign vb_go_c = VB_SYNC ? vb_rise : 1'b1;
    assign xfer_c  = host_valid & host_ready;

    // Next-state and next-output computation
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        tv_n       = table_valid;
        err_n      = error;
        idle_cnt_n = idle_cnt;
        wr_n       = 1'b0;
        addr_n     = gamma_wr_addr;
        val_n      = gamma_value;
        done_n     = 1'b0;

        case (state)
            INIT: begin
                wr_n   = 1'b1;
                addr_n = ptr;
                val_n  = ptr.idx;
                ptr_n  = next_addr(ptr);
                if (is_last(ptr)) begin
                    state_n = IDLE;
                    ptr_n   = '0;
                end
            end
            IDLE: begin
                if (load_start) begin
                    state_n = ARM;
                    err_n   = 1'b0;
                end else if (init_req) begin
                    state_n = INIT;
                    ptr_n   = '0;
                end
            end
            ARM: begin
                if (vb_go_c) begin
                    tv_n       = 1'b0;
                    state_n    = LOAD;
                    ptr_n      = '0;
                    idle_cnt_n = '0;
                end
            end
            LOAD: begin
                if (xfer_c) begin
                    wr_n       = 1'b1;
                    addr_n     = ptr;
                    val_n      = host_data;
                    ptr_n      = next_addr(ptr);
                    idle_cnt_n = '0;
                    if (is_last(ptr)) begin
                        state_n = COMMIT_WAIT;
                    end
                end else if (idle_cnt == CNT_W'(TIMEOUT - 1)) begin
                    // Abandon the partial table; INIT restores identity
                    err_n   = 1'b1;
                    state_n = INIT;
                    ptr_n   = '0;
                end else begin
                    idle_cnt_n = idle_cnt + CNT_W'(1);
                end
            end
            COMMIT_WAIT: begin
                if (vb_go_c) begin
                    tv_n    = 1'b1;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = INIT;
                ptr_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state         <= INIT;
            ptr           <= '0;
            table_valid   <= 1'b0;
            idle_cnt      <= '0;
            host_ready    <= 1'b0;
            gamma_en      <= 1'b0;
            gamma_wr      <= 1'b0;
            gamma_wr_addr <= '0;
            gamma_value   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            table_valid   <= tv_n;
            idle_cnt      <= idle_cnt_n;
            host_ready    <= (state_n == LOAD);
            gamma_en      <= user_en & tv_n & (state_n != LOAD) & (state_n != COMMIT_WAIT);
            gamma_wr      <= wr_n;
            gamma_wr_addr <= addr_n;
            gamma_value   <= val_n;
            busy          <= (state_n != IDLE);
            done          <= done_n;
            error         <= err_n;
        end
    end

endmodule

// File: tb/tb_gamma_loader.sv
// Scoreboard bench for gamma_loader: expected LUT writes are queued by the
// stimulus and consumed by an independent write monitor.
module tb_gamma_loader;

    localparam int unsigned TIMEOUT = 100;
    localparam int          N_ENT   = 768;

    logic       clk_sys    = 1'b0;
    logic       reset_n    = 1'b0;
    logic       user_en    = 1'b1;
    logic       init_req   = 1'b0;
    logic       load_start = 1'b0;
    logic       host_valid = 1'b0;
    logic [7:0] host_data  = 8'h00;
    logic       vblank     = 1'b0;
    logic       host_ready, gamma_en, gamma_wr, busy, done, error;
    logic [9:0] gamma_wr_addr;
    logic [7:0] gamma_value;

    logic [17:0] exp_q[$];
    int n_checks = 0;
    int n_fails  = 0;

    gamma_loader #(
        .TIMEOUT (TIMEOUT),
        .VB_SYNC (1'b1)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .user_en       (user_en),
        .init_req      (init_req),
        .load_start    (load_start),
        .host_valid    (host_valid),
        .host_data     (host_data),
        .host_ready    (host_ready),
        .vblank        (vblank),
        .gamma_en      (gamma_en),
        .gamma_wr      (gamma_wr),
        .gamma_wr_addr (gamma_wr_addr),
        .gamma_value   (gamma_value),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte k of a stream lands on channel k%3, index k/3
    function automatic logic [9:0] exp_addr(input int k);
        return 10'((k % 3) * 256 + k / 3);
    endfunction

    task automatic push_identity();
        for (int k = 0; k < N_ENT; k++)
            exp_q.push_back({exp_addr(k), 8'(k / 3)});
    endtask

    // Write monitor: every LUT write must match the head of the queue
    initial begin : monitor
        logic        xfer_prev;
        logic [17:0] e;
        xfer_prev = 1'b0;
        forever begin
            @(negedge clk_sys);
            #1;
            if (reset_n) begin
                if (xfer_prev) check("wr_after_xfer", 32'(gamma_wr), 32'd1);
                if (gamma_wr) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("FAIL unexpected_write: addr 0x%0h value 0x%0h with empty queue at %0t",
                                 gamma_wr_addr, gamma_value, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 32'(gamma_wr_addr), 32'(e[17:8]));
                        check("wr_value", 32'(gamma_value), 32'(e[7:0]));
                    end
                end
                xfer_prev = host_valid & host_ready;
            end else begin
                xfer_prev = 1'b0;
            end
        end
    end

    task automatic pulse_inputs(input logic ld, input logic in);
        load_start = ld;
        init_req   = in;
        @(negedge clk_sys);
        load_start = 1'b0;
        init_req   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        check({name, "_idle"}, 32'(busy), 32'd0);
        @(negedge clk_sys);
        check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic vblank_arm(input logic exp_en_before);
        int   n = 0;
        logic en_last;
        en_last = gamma_en;
        vblank  = 1'b1;
        while (!host_ready && n < 10) begin
            en_last = gamma_en;
            @(negedge clk_sys);
            n++;
        end
        vblank = 1'b0;
        check("arm_latency", 32'(n), 32'd4);
        check("gamma_en_before_load", 32'(en_last), 32'(exp_en_before));
        check("gamma_en_in_load", 32'(gamma_en), 32'd0);
        check("error_in_load", 32'(error), 32'd0);
    endtask

    task automatic vblank_commit();
        int n = 0;
        check("commit_ready_low", 32'(host_ready), 32'd0);
        check("commit_busy", 32'(busy), 32'd1);
        vblank = 1'b1;
        while (!done && n < 10) begin
            @(negedge clk_sys);
            n++;
        end
        vblank = 1'b0;
        check("done_latency", 32'(n), 32'd4);
        check("gamma_en_commit", 32'(gamma_en), 32'(user_en));
        check("busy_after_commit", 32'(busy), 32'd0);
        @(negedge clk_sys);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    // mode 0: data = 255 - idx, mode 1: random data
    task automatic send_bytes(input int n, input int gap, input int mode, input int k0);
        for (int k = 0; k < n; k++) begin
            int         b = 0;
            logic [7:0] d;
            while (!host_ready && b < 200) begin
                @(negedge clk_sys);
                b++;
            end
            if (!host_ready) begin
                check("host_ready_wait", 32'(host_ready), 32'd1);
                return;
            end
            d = (mode != 0) ? 8'($urandom) : 8'(255 - (k0 + k) / 3);
            host_valid = 1'b1;
            host_data  = d;
            exp_q.push_back({exp_addr(k0 + k), d});
            @(negedge clk_sys);
            host_valid = 1'b0;
            host_data  = 8'($urandom);
            repeat (gap) @(negedge clk_sys);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;

        // Reset state and identity build
        #12;
        check("rst_gamma_wr", 32'(gamma_wr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_host_ready", 32'(host_ready), 32'd0);
        check("rst_gamma_en", 32'(gamma_en), 32'd0);
        check("rst_addr", 32'(gamma_wr_addr), 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        push_identity();
        @(negedge clk_sys);
        check("init_busy", 32'(busy), 32'd1);
        wait_idle("init0");
        check("init0_gamma_en", 32'(gamma_en), 32'd0);
        check("init0_done", 32'(done), 32'd0);

        // Back-to-back load, data = 255 - idx
        pulse_inputs(1'b1, 1'b0);
        vblank_arm(1'b0);
        send_bytes(N_ENT, 0, 0, 0);
        vblank_commit();
        check("load1_error", 32'(error), 32'd0);
        user_en = 1'b0;
        @(negedge clk_sys);
        check("user_en_off", 32'(gamma_en), 32'd0);
        user_en = 1'b1;
        @(negedge clk_sys);
        check("user_en_on", 32'(gamma_en), 32'd1);

        // Stalled host: 1 byte on, 3 cycles off
        pulse_inputs(1'b1, 1'b0);
        vblank_arm(1'b1);
        send_bytes(N_ENT, 3, 1, 0);
        check("stall_no_timeout", 32'(error), 32'd0);
        vblank_commit();

        // Timeout after 400 bytes
        pulse_inputs(1'b1, 1'b0);
        vblank_arm(1'b1);
        send_bytes(400, 0, 1, 0);
        n = 0;
        check("timeout_not_early", 32'(error), 32'd0);
        while (!error && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        push_identity();
        check("timeout_cycles", 32'(n), 32'(TIMEOUT));
        check("timeout_ready_low", 32'(host_ready), 32'd0);
        check("timeout_busy", 32'(busy), 32'd1);
        wait_idle("timeout_init");
        check("timeout_gamma_en", 32'(gamma_en), 32'd0);
        check("timeout_error_sticky", 32'(error), 32'd1);

        // init_req + load_start together: load wins, error cleared
        pulse_inputs(1'b1, 1'b1);
        check("collide_busy", 32'(busy), 32'd1);
        check("collide_error_clr", 32'(error), 32'd0);
        repeat (5) @(negedge clk_sys);
        check("collide_arm_ready", 32'(host_ready), 32'd0);
        vblank_arm(1'b0);
        send_bytes(10, 0, 1, 0);
        pulse_inputs(1'b0, 1'b1);
        check("init_in_load_ignored", 32'(host_ready), 32'd1);
        send_bytes(N_ENT - 10, 0, 1, 10);
        vblank_commit();

        // load_start during INIT is ignored; INIT keeps table_valid
        push_identity();
        pulse_inputs(1'b0, 1'b1);
        repeat (5) @(negedge clk_sys);
        pulse_inputs(1'b1, 1'b0);
        wait_idle("init2");
        check("init2_gamma_en", 32'(gamma_en), 32'd1);
        repeat (3) @(negedge clk_sys);
        check("ld_in_init_busy", 32'(busy), 32'd0);
        check("ld_in_init_ready", 32'(host_ready), 32'd0);

        // Async reset in the middle of a load
        pulse_inputs(1'b1, 1'b0);
        vblank_arm(1'b1);
        send_bytes(200, 0, 1, 0);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_gamma_wr", 32'(gamma_wr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(host_ready), 32'd0);
        check("mid_rst_addr", 32'(gamma_wr_addr), 32'd0);
        check("mid_rst_value", 32'(gamma_value), 32'd0);
        check("mid_rst_error", 32'(error), 32'd0);
        check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        push_identity();
        @(negedge clk_sys);
        check("mid_rst_init_busy", 32'(busy), 32'd1);
        wait_idle("mid_rst_init");
        check("mid_rst_final_error", 32'(error), 32'd0);
        check("mid_rst_final_en", 32'(gamma_en), 32'd0);

        repeat (5) @(negedge clk_sys);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
